// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: shares one serial Mealy pattern detector among NREQ requesters.
// Define SEQ_SCAN_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module seq_scan_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int PLEN  = 2,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic [PLEN-1:0]       pattern,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  ser_x,
  output logic                  hit,
  output logic                  done,
  output logic [CNT_W-1:0]      match_cnt
);
  localparam int IW = $clog2(NREQ);
  localparam int NW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] word;
  logic [PLEN-1:0]  pat, win, cat;
  logic [NW-1:0]    n;
  logic [IW-1:0]    widx, j;
  logic             any;
`ifdef SEQ_SCAN_FIXED_PRIO_EN
  always_comb begin
    widx = '0;
    any  = 1'b0;
    j    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = IW'(i);
      if (req[j]) begin
        widx = j;
        any  = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] ptr;
  // walk from farthest to nearest offset so the first requester after ptr wins
  always_comb begin
    widx = '0;
    any  = 1'b0;
    j    = '0;
    for (int i = NREQ; i >= 1; i--) begin
      j = IW'((int'(ptr) + i) % NREQ);
      if (req[j]) begin
        widx = j;
        any  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= IW'(NREQ - 1);
    else if (state == IDLE && any) ptr <= widx;
`endif
  assign busy  = state != IDLE;
  assign done  = state == DONE;
  assign ser_x = state == SHIFT && word[WIDTH-1];
  assign cat   = PLEN'({win, ser_x});
  assign hit   = state == SHIFT && n >= NW'(PLEN - 1) && cat == pat;
  always_comb begin
    state_n = state;
    if (state == IDLE && any) state_n = SHIFT;
    if (state == SHIFT && n == NW'(WIDTH - 1)) state_n = DONE;
    if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      gnt       <= '0;
      word      <= '0;
      pat       <= '0;
      win       <= '0;
      n         <= '0;
      match_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        gnt       <= NREQ'(1) << widx;
        word      <= data[widx*WIDTH +: WIDTH];
        pat       <= pattern;
        win       <= '0;
        n         <= '0;
        match_cnt <= '0;
      end
      if (state == SHIFT) begin
        word <= word << 1;
        win  <= cat;
        n    <= n + 1'b1;
        if (hit && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
      end
      if (state == DONE) gnt <= '0;
    end
endmodule
